// File: rtl/pe_psum_accumulator.sv
// Accumulates a programmable number of sign-extended PE_sum beats per result and queues results in a small output FIFO.
// Optional macro PE_PSUM_SATURATE_EN: saturating adds with a sticky acc_ovf flag (default build wraps, acc_ovf stays 0).
module pe_psum_accumulator #(
   parameter int SUM_W      = 20,
   parameter int ACC_W      = 32,
   parameter int LEN_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [LEN_W-1:0]              cfg_len,
   input  logic                          abort,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [SUM_W-1:0]              PE_sum,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ACC_W-1:0]              out_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy,
   output logic                          acc_ovf
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovf_q, ovf_d;
   logic [ACC_W-1:0]   mem_q [FIFO_DEPTH];
   logic [ACC_W-1:0]   mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [ACC_W-1:0]   last_q, last_d;

   logic               fifo_full;
   logic               accept;
   logic               pop;
   logic               push;
   logic [ACC_W-1:0]   push_data;
   logic [ACC_W-1:0]   term;
   logic [ACC_W-1:0]   sum_res;
   logic               sat_evt;
   logic [LEN_W-1:0]   len_eff;

   assign term      = ACC_W'($signed(PE_sum));
   assign len_eff   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
   assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
   assign in_ready  = !fifo_full && !abort;
   assign accept    = in_valid && in_ready;
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;
   assign busy      = (state_q == ACCUM);
   assign acc_ovf   = ovf_q;
   assign fifo_count = count_q;
   // Once the FIFO drains, keep presenting the last popped result.
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : last_q;

`ifdef PE_PSUM_SATURATE_EN
   logic [ACC_W:0] sum_ext;
   assign sum_ext = {acc_q[ACC_W-1], acc_q} + {term[ACC_W-1], term};
   always_comb begin
      sat_evt = (sum_ext[ACC_W] != sum_ext[ACC_W-1]);
      sum_res = sum_ext[ACC_W-1:0];
      if (sat_evt)
         sum_res = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
   end
`else
   assign sum_res = acc_q + term;
   assign sat_evt = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      ovf_d     = ovf_q;
      push      = 1'b0;
      push_data = '0;
      if (abort) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
      end else if (accept) begin
         case (state_q)
            IDLE: begin
               len_d = len_eff;
               if (len_eff == LEN_W'(1)) begin
                  push      = 1'b1;
                  push_data = term;
               end else begin
                  acc_d   = term;
                  cnt_d   = LEN_W'(1);
                  state_d = ACCUM;
               end
            end
            ACCUM: begin
               ovf_d = ovf_q | sat_evt;
               if (cnt_q + LEN_W'(1) == len_q) begin
                  push      = 1'b1;
                  push_data = sum_res;
                  acc_d     = '0;
                  cnt_d     = '0;
                  state_d   = IDLE;
               end else begin
                  acc_d = sum_res;
                  cnt_d = cnt_q + LEN_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Pushes are gated by in_ready, so a push never lands on a full FIFO.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      last_d   = last_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         last_d   = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop)
         count_d = count_q + CNT_W'(1);
      else if (pop && !push)
         count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         len_q    <= LEN_W'(1);
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         last_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         last_q   <= last_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: tb/tb_pe_psum_accumulator.sv
// Directed, table-driven bench for pe_psum_accumulator; a second ACC_W=20 instance covers the wrap/saturate boundary.
module tb_pe_psum_accumulator;

   logic        clk;
   logic        reset;
   logic [7:0]  cfg_len;
   logic        abort;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] PE_sum;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  fifo_count;
   logic        busy;
   logic        acc_ovf;

   logic [7:0]  w_cfg_len;
   logic        w_abort;
   logic        w_in_valid;
   logic        w_in_ready;
   logic [19:0] w_PE_sum;
   logic        w_out_valid;
   logic        w_out_ready;
   logic [19:0] w_out_data;
   logic [2:0]  w_fifo_count;
   logic        w_busy;
   logic        w_acc_ovf;

   int tests_run = 0;
   int tests_failed = 0;

   pe_psum_accumulator dut (
      .clk(clk), .reset(reset), .cfg_len(cfg_len), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .PE_sum(PE_sum),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .fifo_count(fifo_count), .busy(busy), .acc_ovf(acc_ovf)
   );

   pe_psum_accumulator #(.ACC_W(20)) dut_w (
      .clk(clk), .reset(reset), .cfg_len(w_cfg_len), .abort(w_abort),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .PE_sum(w_PE_sum),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
      .fifo_count(w_fifo_count), .busy(w_busy), .acc_ovf(w_acc_ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   typedef struct {
      logic valid;
      int   sum;
      int   len;
      logic abrt;
      logic ordy;
      logic exp_in_ready;
      logic exp_valid;
      int   exp_data;
      logic exp_busy;
      int   exp_count;
   } vec_t;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input vec_t v, input int idx);
      in_valid  = v.valid;
      PE_sum    = 20'(v.sum);
      cfg_len   = 8'(v.len);
      abort     = v.abrt;
      out_ready = v.ordy;
      #1;
      check_output($sformatf("vec%0d in_ready", idx), 32'(in_ready), 32'(v.exp_in_ready));
      tick();
      check_output($sformatf("vec%0d out_valid", idx), 32'(out_valid), 32'(v.exp_valid));
      check_output($sformatf("vec%0d out_data", idx), out_data, 32'(v.exp_data));
      check_output($sformatf("vec%0d busy", idx), 32'(busy), 32'(v.exp_busy));
      check_output($sformatf("vec%0d fifo_count", idx), 32'(fifo_count), 32'(v.exp_count));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      abort = 1'b0;
      w_in_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic beat(input int val, input int len, input logic ordy);
      in_valid  = 1'b1;
      PE_sum    = 20'(val);
      cfg_len   = 8'(len);
      out_ready = ordy;
      tick();
      in_valid  = 1'b0;
   endtask

   vec_t vecs [15];
   int   beats [20];
   int   exp_res [10];

   initial begin
      int idx;
      int pop_idx;
      int cycles;
      logic acc_now;
      logic first;

      reset = 1'b1;
      cfg_len = 8'd0;
      abort = 1'b0;
      in_valid = 1'b0;
      PE_sum = '0;
      out_ready = 1'b1;
      w_cfg_len = 8'd2;
      w_abort = 1'b0;
      w_in_valid = 1'b0;
      w_PE_sum = '0;
      w_out_ready = 1'b1;

      //           valid  sum  len abrt ordy  ir  ov  data busy cnt
      vecs[0]  = '{1'b1,    5,  4, 1'b0, 1'b1, 1'b1, 1'b0,   0, 1'b1, 0};
      vecs[1]  = '{1'b1,   -3,  1, 1'b0, 1'b1, 1'b1, 1'b0,   0, 1'b1, 0};
      vecs[2]  = '{1'b1,  100,  4, 1'b0, 1'b1, 1'b1, 1'b0,   0, 1'b1, 0};
      vecs[3]  = '{1'b1,   -2,  4, 1'b0, 1'b1, 1'b1, 1'b1, 100, 1'b0, 1};
      vecs[4]  = '{1'b0,    0,  0, 1'b0, 1'b1, 1'b1, 1'b0, 100, 1'b0, 0};
      vecs[5]  = '{1'b1,    7,  0, 1'b0, 1'b1, 1'b1, 1'b1,   7, 1'b0, 1};
      vecs[6]  = '{1'b1,   -8,  0, 1'b0, 1'b1, 1'b1, 1'b1,  -8, 1'b0, 1};
      vecs[7]  = '{1'b0,    0,  0, 1'b0, 1'b1, 1'b1, 1'b0,  -8, 1'b0, 0};
      vecs[8]  = '{1'b1,    1,  3, 1'b0, 1'b1, 1'b1, 1'b0,  -8, 1'b1, 0};
      vecs[9]  = '{1'b1,    2,  3, 1'b0, 1'b1, 1'b1, 1'b0,  -8, 1'b1, 0};
      vecs[10] = '{1'b1,   99,  3, 1'b1, 1'b1, 1'b0, 1'b0,  -8, 1'b0, 0};
      vecs[11] = '{1'b1,    4,  3, 1'b0, 1'b1, 1'b1, 1'b0,  -8, 1'b1, 0};
      vecs[12] = '{1'b1,    5,  3, 1'b0, 1'b1, 1'b1, 1'b0,  -8, 1'b1, 0};
      vecs[13] = '{1'b1,    6,  3, 1'b0, 1'b1, 1'b1, 1'b1,  15, 1'b0, 1};
      vecs[14] = '{1'b0,    0,  3, 1'b0, 1'b1, 1'b1, 1'b0,  15, 1'b0, 0};

      for (int i = 0; i < 20; i++)
         beats[i] = i * 7 - 30;
      for (int r = 0; r < 10; r++)
         exp_res[r] = beats[2*r] + beats[2*r+1];

      // Reset values
      do_reset();
      check_output("rst out_valid", 32'(out_valid), 32'd0);
      check_output("rst out_data", out_data, 32'd0);
      check_output("rst fifo_count", 32'(fifo_count), 32'd0);
      check_output("rst busy", 32'(busy), 32'd0);
      check_output("rst acc_ovf", 32'(acc_ovf), 32'd0);
      check_output("rst in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 15; i++)
         apply_stimulus(vecs[i], i);

      // FIFO fill with out_ready low, then drain in order
      do_reset();
      out_ready = 1'b0;
      cfg_len = 8'd2;
      idx = 0;
      for (int c = 0; c < 14; c++) begin
         in_valid = (idx < 20);
         PE_sum = 20'(beats[idx % 20]);
         #1;
         acc_now = in_valid && in_ready;
         tick();
         if (acc_now) idx++;
      end
      in_valid = 1'b1;
      PE_sum = 20'(beats[idx % 20]);
      #1;
      check_output("full beats accepted", 32'(idx), 32'd8);
      check_output("full fifo_count", 32'(fifo_count), 32'd4);
      check_output("full in_ready", 32'(in_ready), 32'd0);
      check_output("full head held", out_data, 32'(exp_res[0]));
      out_ready = 1'b1;
      #1;
      check_output("full pop in_ready same cycle", 32'(in_ready), 32'd0);
      pop_idx = 0;
      cycles = 0;
      first = 1'b1;
      while (!(pop_idx == 10 && idx == 20) && cycles < 80) begin
         in_valid = (idx < 20);
         PE_sum = 20'(beats[idx % 20]);
         #1;
         if (out_valid && out_ready) begin
            if (pop_idx < 10)
               check_output($sformatf("drain result %0d", pop_idx), out_data, 32'(exp_res[pop_idx]));
            else
               check_output("drain extra result", 32'(pop_idx), 32'd9);
            pop_idx++;
         end
         acc_now = in_valid && in_ready;
         tick();
         if (acc_now) idx++;
         if (first) begin
            check_output("full pop in_ready next cycle", 32'(in_ready), 32'd1);
            first = 1'b0;
         end
         cycles++;
      end
      in_valid = 1'b0;
      check_output("drain count", 32'(pop_idx), 32'd10);
      check_output("drain fifo_count", 32'(fifo_count), 32'd0);
      check_output("acc_ovf stays low", 32'(acc_ovf), 32'd0);

      // Wrap / saturation at ACC_W == SUM_W
      w_cfg_len = 8'd2;
      w_in_valid = 1'b1;
      w_PE_sum = 20'h7FFFF;
      tick();
      tick();
      w_in_valid = 1'b0;
      check_output("w out_valid", 32'(w_out_valid), 32'd1);
`ifdef PE_PSUM_SATURATE_EN
      check_output("w out_data", 32'(w_out_data), 32'h7FFFF);
      check_output("w acc_ovf", 32'(w_acc_ovf), 32'd1);
`else
      check_output("w out_data", 32'(w_out_data), 32'hFFFFE);
      check_output("w acc_ovf", 32'(w_acc_ovf), 32'd0);
`endif

      // Reset in the middle of a job with FIFO entries pending
      do_reset();
      beat(11, 1, 1'b0);
      beat(22, 1, 1'b0);
      beat(1, 4, 1'b0);
      beat(2, 4, 1'b0);
      check_output("mid fifo_count before", 32'(fifo_count), 32'd2);
      check_output("mid busy before", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_output("mid fifo_count", 32'(fifo_count), 32'd0);
      check_output("mid out_valid", 32'(out_valid), 32'd0);
      check_output("mid busy", 32'(busy), 32'd0);
      beat(3, 4, 1'b1);
      beat(4, 4, 1'b1);
      beat(5, 4, 1'b1);
      beat(6, 4, 1'b1);
      check_output("mid new out_valid", 32'(out_valid), 32'd1);
      check_output("mid new out_data", out_data, 32'd18);
      tick();
      check_output("mid new single result", 32'(out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pe_psum_accumulator.md
Name: pe_psum_accumulator

Overview:
- Output stage directly downstream of the fusion-unit PE; consumes its 20-bit PE_sum stream.
- Sign-extends each PE_sum and accumulates a programmable number of beats (one output pixel / dot-product) into a wide accumulator.
- Finished results are pushed into a small output FIFO drained through a valid/ready handshake toward the output buffer.

Parameters:
- SUM_W, 20, width of incoming PE_sum (signed two's complement)
- ACC_W, 32, accumulator and result width (signed); must be >= SUM_W
- LEN_W, 8, width of beat-count configuration
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- cfg_len  in  LEN_W  beats per result; sampled on the first beat of each job; 0 is treated as 1
- abort  in  1  drop the in-progress partial sum; FIFO contents kept
- in_valid  in  1  PE_sum beat valid
- in_ready  out  1  block can accept a beat
- PE_sum  in  SUM_W  signed partial sum from PE
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  ACC_W  accumulated result at FIFO head
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- busy  out  1  a job is in progress (state ACCUM)
- acc_ovf  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset (sync, high): state=IDLE, acc=0, beat count=0, latched length=1, FIFO empty, out_valid=0, out_data=0, fifo_count=0, busy=0, acc_ovf=0, in_ready=1 on the first cycle after reset.
- Beat accepted when in_valid && in_ready. in_ready = !fifo_full && !abort.
- Arithmetic: term = PE_sum sign-extended to ACC_W. Default: sum wraps modulo 2^ACC_W.
- FSM IDLE: on an accepted beat, latch len = (cfg_len==0 ? 1 : cfg_len).
  - If len==1, push term to FIFO and stay IDLE.
  - Otherwise acc=term, count=1, go to ACCUM.
- FSM ACCUM: on an accepted beat, if count+1 == len, push acc+term to FIFO, clear acc and count, and go to IDLE. Otherwise acc+=term and count+=1.
  - cfg_len changes during ACCUM are ignored.
- abort: forces IDLE with acc=0 and count=0. The same-cycle beat is not accepted (in_ready=0). FIFO contents and acc_ovf are unaffected.
- FIFO: registered storage; pushed result appears at out_valid/out_data the cycle after the final beat is accepted (latency 1 cycle from final beat).
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop: occupancy unchanged, order preserved.
  - out_data holds its value while out_valid && !out_ready.
  - When empty, out_valid=0 and out_data holds its last value.
- Full: in_ready=0, so no beat (final or not) is accepted. A pop while full raises in_ready the following cycle.
- Read/write pointers wrap modulo FIFO_DEPTH.
- busy=1 exactly while state==ACCUM.

Optional Feature:
- Macro PE_PSUM_SATURATE_EN.
- Defined: each addition saturates to the signed ACC_W range [-2^(ACC_W-1), 2^(ACC_W-1)-1]. acc_ovf sets on any saturation event and is cleared only by reset.
- Undefined: wrap-around arithmetic as above and acc_ovf is tied to 0.

Test Plan:
- Reset, then cfg_len=4, beats 5, -3, 100, -2 (in_valid every cycle, out_ready=1) -> out_valid one cycle after 4th beat with out_data=100; busy high for beats 2-4 only.
- cfg_len=0 with beats 7, -8 -> two results 7 and -8 (0 treated as 1), each 1 cycle after its beat; busy never asserts.
- cfg_len=2, out_ready=0, feed 10 results (FIFO_DEPTH=4) -> in_ready drops after 4 results with fifo_count=4; raising out_ready drains results in order with no loss or duplication.
- cfg_len=3, beats 1, 2, then abort, then beats 4, 5, 6 -> single result 15; the partial 3 is never output.
- ACC_W=20, cfg_len=2, PE_sum=0x7FFFF twice -> without macro out_data=0xFFFFE (wrapped), acc_ovf=0; with PE_PSUM_SATURATE_EN out_data=0x7FFFF and acc_ovf=1.
- Assert reset mid-job (cfg_len=4 after 2 beats, FIFO holding 2 entries) -> next cycle fifo_count=0, out_valid=0, busy=0; the next 4-beat job produces only its own sum.
